// File: rtl/cache_pkg.sv
// Shared types and defaults for the write-through data cache controller.
package cache_pkg;
  localparam int CACHE_ADDR_W   = 10;
  localparam int CACHE_INDEX_W  = 5;
  localparam int CACHE_OFFSET_W = 2;
  localparam int CACHE_DATA_W   = 32;
  localparam int CACHE_TAG_W    = CACHE_ADDR_W - CACHE_INDEX_W - CACHE_OFFSET_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } cache_state_e;

  typedef logic [CACHE_ADDR_W-1:0] caddr_t;

  function automatic logic [CACHE_TAG_W-1:0] addr_tag(input caddr_t a);
    return a[CACHE_ADDR_W-1 -: CACHE_TAG_W];
  endfunction

  function automatic logic [CACHE_INDEX_W-1:0] addr_index(input caddr_t a);
    return a[CACHE_INDEX_W+CACHE_OFFSET_W-1 -: CACHE_INDEX_W];
  endfunction

  function automatic logic [CACHE_OFFSET_W-1:0] addr_offset(input caddr_t a);
    return a[CACHE_OFFSET_W-1:0];
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction
endpackage

// File: rtl/dcache_wt_ctrl_if.sv
// Core-side and memory-side buses of the data cache controller.
interface dcache_cpu_if import cache_pkg::*; #(
  parameter int ADDR_W = CACHE_ADDR_W,
  parameter int DATA_W = CACHE_DATA_W
);
  logic [ADDR_W-1:0] cpu_addr;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              stall;
  logic [15:0]       rd_hit_cnt;
  logic [15:0]       rd_miss_cnt;

  modport master (output cpu_addr, mem_read, mem_write, cpu_wdata,
                  input  cpu_rdata, stall, rd_hit_cnt, rd_miss_cnt);
  modport slave  (input  cpu_addr, mem_read, mem_write, cpu_wdata,
                  output cpu_rdata, stall, rd_hit_cnt, rd_miss_cnt);
endinterface

interface dcache_mem_if import cache_pkg::*; #(
  parameter int ADDR_W = CACHE_ADDR_W,
  parameter int DATA_W = CACHE_DATA_W
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (output mem_addr, mem_rd, mem_wr, mem_wdata,
                  input  mem_rdata, mem_ready);
  modport slave  (input  mem_addr, mem_rd, mem_wr, mem_wdata,
                  output mem_rdata, mem_ready);
endinterface

// File: rtl/dcache_line_store.sv
// Direct-mapped tag/valid/data store: combinational read + hit, one word-write port.
module dcache_line_store #(
  parameter int INDEX_W  = 5,
  parameter int OFFSET_W = 2,
  parameter int TAG_W    = 3,
  parameter int DATA_W   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INDEX_W-1:0]  rd_index,
  input  logic [OFFSET_W-1:0] rd_offset,
  input  logic [TAG_W-1:0]    rd_tag,
  output logic [DATA_W-1:0]   rd_data,
  output logic                hit,
  input  logic                we,
  input  logic [INDEX_W-1:0]  wr_index,
  input  logic [OFFSET_W-1:0] wr_offset,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                fill_done,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic                inval,
  input  logic [INDEX_W-1:0]  inval_index
);
  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << (INDEX_W + OFFSET_W);

  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [TAG_W-1:0]  tag_d  [LINES];
  logic [DATA_W-1:0] data_q [WORDS];
  logic [DATA_W-1:0] data_d [WORDS];

  assign rd_data = data_q[{rd_index, rd_offset}];
  assign hit     = valid_q[rd_index] && (tag_q[rd_index] == rd_tag);

  // Invalidate at refill start so an interrupted refill never looks valid.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (inval) valid_d[inval_index] = 1'b0;
    if (fill_done) begin
      valid_d[wr_index] = 1'b1;
      tag_d[wr_index]   = fill_tag;
    end
    if (we) data_d[{wr_index, wr_offset}] = wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end
endmodule

// File: rtl/dcache_wt_ctrl.sv
// Direct-mapped write-through, no-write-allocate data cache controller.
module dcache_wt_ctrl import cache_pkg::*; #(
  parameter int ADDR_W   = CACHE_ADDR_W,
  parameter int INDEX_W  = CACHE_INDEX_W,
  parameter int OFFSET_W = CACHE_OFFSET_W,
  parameter int DATA_W   = CACHE_DATA_W
) (
  input logic         clk,
  input logic         rst_n,
  dcache_cpu_if.slave cpu,
  dcache_mem_if.master mem
);
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

  cache_state_e        state_q, state_d;
  logic [ADDR_W-1:0]   buf_addr_q, buf_addr_d;
  logic [DATA_W-1:0]   buf_wdata_q, buf_wdata_d;
  logic [OFFSET_W-1:0] cnt_q, cnt_d;
  logic [15:0]         hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  logic [INDEX_W-1:0]  cpu_index, buf_index, wr_index;
  logic [OFFSET_W-1:0] wr_offset;
  logic [DATA_W-1:0]   st_rdata, wr_data;
  logic                st_hit, we, fill_done, inval;

  assign cpu_index = cpu.cpu_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
  assign buf_index = buf_addr_q[INDEX_W+OFFSET_W-1:OFFSET_W];

  dcache_line_store #(
    .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W), .TAG_W(TAG_W), .DATA_W(DATA_W)
  ) u_store (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_index   (cpu_index),
    .rd_offset  (cpu.cpu_addr[OFFSET_W-1:0]),
    .rd_tag     (cpu.cpu_addr[ADDR_W-1:INDEX_W+OFFSET_W]),
    .rd_data    (st_rdata),
    .hit        (st_hit),
    .we         (we),
    .wr_index   (wr_index),
    .wr_offset  (wr_offset),
    .wr_data    (wr_data),
    .fill_done  (fill_done),
    .fill_tag   (buf_addr_q[ADDR_W-1:INDEX_W+OFFSET_W]),
    .inval      (inval),
    .inval_index(cpu_index)
  );

  assign cpu.rd_hit_cnt  = hit_cnt_q;
  assign cpu.rd_miss_cnt = miss_cnt_q;

  always_comb begin
    state_d       = state_q;
    buf_addr_d    = buf_addr_q;
    buf_wdata_d   = buf_wdata_q;
    cnt_d         = cnt_q;
    hit_cnt_d     = hit_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    we            = 1'b0;
    wr_index      = buf_index;
    wr_offset     = cnt_q;
    wr_data       = mem.mem_rdata;
    fill_done     = 1'b0;
    inval         = 1'b0;
    cpu.stall     = 1'b0;
    cpu.cpu_rdata = '0;
    mem.mem_rd    = 1'b0;
    mem.mem_wr    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        if (cpu.mem_write) begin
          cpu.stall   = 1'b1;
          buf_addr_d  = cpu.cpu_addr;
          buf_wdata_d = cpu.cpu_wdata;
          if (st_hit) begin
            we        = 1'b1;
            wr_index  = cpu_index;
            wr_offset = cpu.cpu_addr[OFFSET_W-1:0];
            wr_data   = cpu.cpu_wdata;
          end
          state_d = ST_WRITE;
        end else if (cpu.mem_read) begin
          if (st_hit) begin
            cpu.cpu_rdata = st_rdata;
            hit_cnt_d     = sat_inc(hit_cnt_q);
          end else begin
            cpu.stall  = 1'b1;
            buf_addr_d = {cpu.cpu_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
            cnt_d      = '0;
            miss_cnt_d = sat_inc(miss_cnt_q);
            inval      = 1'b1;
            state_d    = ST_REFILL;
          end
        end
      end
      ST_REFILL: begin
        cpu.stall    = 1'b1;
        mem.mem_rd   = 1'b1;
        mem.mem_addr = {buf_addr_q[ADDR_W-1:OFFSET_W], cnt_q};
        if (mem.mem_ready) begin
          we    = 1'b1;
          cnt_d = cnt_q + OFFSET_W'(1);
          if (cnt_q == {OFFSET_W{1'b1}}) begin
            fill_done = 1'b1;
            state_d   = ST_DONE;
          end
        end
      end
      ST_WRITE: begin
        cpu.stall     = 1'b1;
        mem.mem_wr    = 1'b1;
        mem.mem_addr  = buf_addr_q;
        mem.mem_wdata = buf_wdata_q;
        if (mem.mem_ready) state_d = ST_DONE;
      end
      ST_DONE: begin
        // One-cycle release; the held request is answered from the store, not re-decoded.
        cpu.cpu_rdata = st_rdata;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      buf_addr_q  <= '0;
      buf_wdata_q <= '0;
      cnt_q       <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      buf_addr_q  <= buf_addr_d;
      buf_wdata_q <= buf_wdata_d;
      cnt_q       <= cnt_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end
endmodule

// File: doc/dcache_wt_ctrl.md
# dcache_wt_ctrl

Direct-mapped, write-through, no-write-allocate data-cache controller between the core's data-memory port (driven by the control unit's Mem_Read/Mem_Write) and a multi-cycle word-wide main memory. Serves read hits combinationally. Stalls the core on read misses, which refill a whole line, and on every write, which goes through to memory. Keeps the tag/valid/data store and 16-bit hit/miss performance counters.

## Interface
- ADDR_W, 10, word-address width
- INDEX_W, 5, line-index width
- OFFSET_W, 2, word-in-line width (4 words/line)
- DATA_W, 32, data width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- cpu_addr  in  ADDR_W  word address; tag=[ADDR_W-1:INDEX_W+OFFSET_W], index=[INDEX_W+OFFSET_W-1:OFFSET_W], offset=[OFFSET_W-1:0]
- mem_read  in  1  load request (control unit Mem_Read)
- mem_write  in  1  store request (control unit Mem_Write)
- cpu_wdata  in  DATA_W  store data
- cpu_rdata  out  DATA_W  load data, valid when mem_read & !stall
- stall  out  1  freeze core; core holds the request stable while high
- mem_addr  out  ADDR_W  memory word address
- mem_rd  out  1  memory read request
- mem_wr  out  1  memory write request
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_ready  in  1  transfer completes on an edge where (mem_rd|mem_wr) & mem_ready
- rd_hit_cnt, rd_miss_cnt  out  16 each  saturating counters

## Operation
- States: IDLE, REFILL, WRITE, DONE.
- IDLE, mem_write=1 (has priority over mem_read):
  - stall=1.
  - Latch addr and data into the write buffer.
  - On a hit, update the cached word at this edge.
  - Go to WRITE.
- IDLE, mem_read & hit: cpu_rdata = line word, stall=0, rd_hit_cnt++.
- IDLE, mem_read & miss: stall=1, latch line base address, clear word counter, rd_miss_cnt++, go to REFILL.
- IDLE, no request: stall=0, no memory activity.
- REFILL:
  - mem_rd=1, mem_addr = {tag,index,cnt}.
  - On each handshake, write mem_rdata into word cnt, then cnt++.
  - After word 3: set valid, write tag, go to DONE.
- WRITE: mem_wr=1, mem_addr and mem_wdata from the write buffer. On handshake go to DONE.
- DONE:
  - stall=0.
  - cpu_rdata = cached word for cpu_addr (the refilled word after a read).
  - Unconditionally return to IDLE. The request is not re-evaluated in DONE.
- Write miss: memory is written, cache unchanged (no allocate).
- A read miss evicts the indexed line regardless of its previous contents. No dirty state exists.
- Counters saturate at 16'hFFFF.

## Timing
- Reset, at the rising edge while rst_n=0:
  - state=IDLE, all valid bits=0, cnt=0, counters=0.
  - mem_rd=mem_wr=0, stall=0 when idle.
  - mem_addr, mem_wdata and cpu_rdata are 0.
- stall, cpu_rdata and the mem_* outputs are decoded combinationally from the state and the latched registers. mem_* never depends combinationally on mem_ready.
- Read hit: 0 stall cycles.
- Read miss with mem_ready tied to 1: stall high 5 cycles (IDLE + 4 REFILL), data in the DONE cycle.
- Write with mem_ready tied to 1: stall high 2 cycles (IDLE + WRITE), released in DONE.
- Each mem_ready wait cycle adds one stall cycle.
- mem_addr and mem_wdata are stable while a request is held. The next refill word is requested on the cycle after a handshake.
- Reset mid-REFILL or mid-WRITE: mem_rd/mem_wr drop in the first cycle after the reset edge. The partial line stays invalid.

## Structure
- Shared package cache_pkg holds:
  - state encodings (IDLE=2'd0, REFILL=2'd1, WRITE=2'd2, DONE=2'd3)
  - default ADDR_W, INDEX_W, OFFSET_W and DATA_W
  - tag/index/offset slice helpers
- One sub-module, dcache_line_store, holds:
  - valid vector, tag array, data array
  - combinational read port and hit compare
  - one synchronous word-write port
  - synchronous clear of valid

## Test plan
- Reset, then read 0x010. Memory returns 0xA0–0xA3 for 0x010–0x013, mem_ready=1. Expect:
  - stall 5 cycles; mem_rd addresses 0x010–0x013
  - cpu_rdata=0xA0 in DONE
  - rd_miss_cnt=1
- Read 0x012 → stall=0 in the same cycle, cpu_rdata=0xA2, rd_hit_cnt=1, no mem_rd.
- Write 0x011 with 0xDEADBEEF, mem_ready delayed 3 cycles. Expect:
  - mem_wr held with addr 0x011 / data 0xDEADBEEF for 3 cycles, stall released in DONE
  - a following read of 0x011 hits and returns 0xDEADBEEF
- Write 0x210 (same index, different tag) → one memory write, no mem_rd. A read of 0x010 still hits. A read of 0x210 then misses and refills 0x210–0x213.
- Assert rst_n=0 after 2 REFILL handshakes → mem_rd=0 the next cycle. A read of 0x010 afterwards misses; counters read 0 before that access.
- mem_read=mem_write=1 at 0x005 → handled as a write: mem_wr, no refill, rd counters unchanged.
